// File: rtl/cpu_launcher_pkg.sv
// Shared types for cpu_launcher: FSM state encoding, program index width
// and the per-program result record.
package launcher_pkg;

    localparam int PROG_W = 3;
    localparam int CYC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        RECORD,
        DRAIN
    } state_t;

    // cycles is the widest supported count; narrower counters are zero-extended
    typedef struct packed {
        logic [PROG_W-1:0] idx;
        logic [CYC_W-1:0]  cycles;
    } result_t;

endpackage

// File: rtl/cpu_launcher_sat_counter.sv
// Up-counter that clears to zero and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_launcher.sv
// Runs NUM_PROGS programs back to back on the processor req/done handshake
// and reports a cycle count per program. Optional run timeout: LAUNCHER_TIMEOUT_EN.
module cpu_launcher
    import launcher_pkg::*;
#(
    parameter int NUM_PROGS   = 3,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              cpu_req,
    input  logic              cpu_done,
    output logic [PROG_W-1:0] prog_sel,
    output logic              busy,
    output logic              res_valid,
    output logic [PROG_W-1:0] res_idx,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              batch_done,
    output logic              timeout_err
);

    localparam logic [PROG_W-1:0] LAST_PROG = PROG_W'(NUM_PROGS - 1);
    localparam logic [31:0]       TO_LIM    = 32'(TIMEOUT_CYC - 1);
`ifdef LAUNCHER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t             state, state_nxt;
    logic [PROG_W-1:0]  prog_q;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_clr, cnt_en;
    logic               to_hit;
    logic               to_flag;
    result_t            res;
    logic               cyc_unused;

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt)
    );

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                cnt_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                // cnt is still zero only in the first RUN cycle, where done may be stale
                if ((cnt != '0) && cpu_done) begin
                    state_nxt = RECORD;
                end else if (TO_EN && (32'(cnt) >= TO_LIM)) begin
                    to_hit    = 1'b1;
                    state_nxt = RECORD;
                end
            end
            RECORD: begin
                state_nxt = (prog_q == LAST_PROG) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (!cpu_done) state_nxt = LAUNCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prog_q  <= '0;
            to_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                prog_q <= '0;
            end else if ((state == DRAIN) && !cpu_done) begin
                prog_q <= prog_q + 1'b1;
            end
            if ((state == RUN) && (state_nxt == RECORD)) begin
                to_flag <= to_hit;
            end
        end
    end

`ifdef LAUNCHER_TIMEOUT_EN
    logic to_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_err <= 1'b0;
        end else if (to_hit) begin
            to_err <= 1'b1;
        end
    end

    assign timeout_err = to_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        res = '0;
        if (state == RECORD) begin
            res.idx    = prog_q;
            res.cycles = CYC_W'(to_flag ? {CNT_W{1'b1}} : cnt);
        end
    end

    assign cyc_unused = ^res.cycles;

    assign cpu_req    = (state == LAUNCH);
    assign busy       = (state != IDLE);
    assign prog_sel   = prog_q;
    assign res_valid  = (state == RECORD);
    assign res_idx    = res.idx;
    assign res_cycles = res.cycles[CNT_W-1:0];
    assign batch_done = (state == RECORD) && (prog_q == LAST_PROG);

endmodule

// File: tb/tb_cpu_launcher.sv
// Directed bench for cpu_launcher: single-program, stale-done, batch,
// saturation, mid-run reset and (with LAUNCHER_TIMEOUT_EN) timeout runs.
module tb_cpu_launcher;

    logic clk = 1'b0;
    logic reset;
    logic start_a, done_a, start_b, done_b;

    logic       a_req, a_busy, a_rv, a_bd, a_to;
    logic [2:0] a_sel, a_idx;
    logic [15:0] a_cyc;
    logic       s_req, s_busy, s_rv, s_bd, s_to;
    logic [2:0] s_sel, s_idx;
    logic [3:0] s_cyc;
    logic       b_req, b_busy, b_rv, b_bd, b_to;
    logic [2:0] b_sel, b_idx;
    logic [15:0] b_cyc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_launcher #(.NUM_PROGS(1), .CNT_W(16), .TIMEOUT_CYC(4096)) u_single (
        .clk(clk), .reset(reset), .start(start_a), .cpu_req(a_req), .cpu_done(done_a),
        .prog_sel(a_sel), .busy(a_busy), .res_valid(a_rv), .res_idx(a_idx),
        .res_cycles(a_cyc), .batch_done(a_bd), .timeout_err(a_to)
    );

    cpu_launcher #(.NUM_PROGS(1), .CNT_W(4), .TIMEOUT_CYC(4096)) u_sat (
        .clk(clk), .reset(reset), .start(start_a), .cpu_req(s_req), .cpu_done(done_a),
        .prog_sel(s_sel), .busy(s_busy), .res_valid(s_rv), .res_idx(s_idx),
        .res_cycles(s_cyc), .batch_done(s_bd), .timeout_err(s_to)
    );

    cpu_launcher #(.NUM_PROGS(3), .CNT_W(16), .TIMEOUT_CYC(16)) u_batch (
        .clk(clk), .reset(reset), .start(start_b), .cpu_req(b_req), .cpu_done(done_b),
        .prog_sel(b_sel), .busy(b_busy), .res_valid(b_rv), .res_idx(b_idx),
        .res_cycles(b_cyc), .batch_done(b_bd), .timeout_err(b_to)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Single-program run on u_single/u_sat: done high for k<=pre (stale) and k>=rise,
    // where k counts cycles from the req cycle.
    task automatic run_single(input int pre, input int rise);
        int  k;
        bit  got;
        done_a  = (pre >= 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_req", a_req, 1);
        chk("a_busy", a_busy, 1);
        chk("a_sel", a_sel, 0);
        chk("s_req", s_req, 1);
        got = 1'b0;
        k   = 0;
        while (!got && k < 80) begin
            done_a = (k <= pre) || (k >= rise);
            @(negedge clk);
            k++;
            if (a_rv) begin
                got = 1'b1;
                chk("a_lat", k, rise + 1);
                chk("a_cycles", a_cyc, rise);
                chk("a_idx", a_idx, 0);
                chk("a_bdone", a_bd, 1);
                chk("a_req_rv", a_req, 0);
                chk("s_rv", s_rv, 1);
                chk("s_cycles", s_cyc, (rise > 15) ? 15 : rise);
            end
        end
        if (!got) chk("a_bound", 0, 1);
        done_a = 1'b0;
        @(negedge clk);
        chk("a_busy_end", a_busy, 0);
        chk("a_rv_end", a_rv, 0);
        chk("s_busy_end", s_busy, 0);
        @(negedge clk);
    endtask

    task automatic run_batch();
        int run_len [3] = '{4, 10, 1};
        int exp_cyc [3] = '{4, 10, 2};
        int k, cur, n_req, n_res, cyc;
        logic prev_done;
        done_b  = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b   = 1'b0;
        k         = 0;
        cur       = 0;
        n_req     = 0;
        n_res     = 0;
        cyc       = 0;
        prev_done = 1'b0;
        while (b_busy && cyc < 150) begin
            if (b_req) begin
                chk("b_req_sel", b_sel, n_req);
                chk("b_gap", prev_done, 0);
                chk("b_req_rv", b_rv, 0);
                k   = 0;
                cur = (n_req < 3) ? n_req : 2;
                n_req++;
            end
            if (b_rv) begin
                chk("b_idx", b_idx, n_res);
                chk("b_cycles", b_cyc, exp_cyc[(n_res < 3) ? n_res : 2]);
                chk("b_bdone", b_bd, (n_res == 2) ? 1 : 0);
                n_res++;
            end
            done_b    = (k >= run_len[cur]) && (k < run_len[cur] + 3);
            prev_done = done_b;
            k++;
            cyc++;
            @(negedge clk);
        end
        chk("b_bound", b_busy, 0);
        chk("b_nreq", n_req, 3);
        chk("b_nres", n_res, 3);
        chk("b_to_clear", b_to, 0);
        done_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_reset_mid();
        int  k;
        bit  seen_rv, seen_busy;
        done_b  = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (!(b_req && b_sel == 3'd1) && k < 40) begin
            done_b = (k == 3);
            @(negedge clk);
            k++;
        end
        chk("r_reached_p1", b_sel, 1);
        done_b = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        start_b = 1'b1;
        done_b  = 1'b1;
        @(negedge clk);
        chk("r_req", b_req, 0);
        chk("r_busy", b_busy, 0);
        chk("r_rv", b_rv, 0);
        chk("r_sel", b_sel, 0);
        chk("r_idx", b_idx, 0);
        chk("r_cyc", b_cyc, 0);
        chk("r_bdone", b_bd, 0);
        reset   = 1'b0;
        start_b = 1'b0;
        seen_rv   = 1'b0;
        seen_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (b_rv) seen_rv = 1'b1;
            if (b_busy) seen_busy = 1'b1;
        end
        chk("r_no_rv", seen_rv, 0);
        chk("r_idle", seen_busy, 0);
        done_b  = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("r_restart_req", b_req, 1);
        chk("r_restart_sel", b_sel, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef LAUNCHER_TIMEOUT_EN
    task automatic run_timeout();
        int k;
        done_b  = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (!b_rv && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t_lat", k, 17);
        chk("t_cycles", b_cyc, 16'hFFFF);
        chk("t_idx", b_idx, 0);
        chk("t_err", b_to, 1);
        @(negedge clk);
        chk("t_err_drain", b_to, 1);
        @(negedge clk);
        chk("t_next_req", b_req, 1);
        chk("t_next_sel", b_sel, 1);
        chk("t_err_sticky", b_to, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t_err_reset", b_to, 0);
    endtask
`endif

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        done_a  = 1'b0;
        start_b = 1'b0;
        done_b  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", b_req, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_rv", b_rv, 0);
        chk("rst_sel", b_sel, 0);
        chk("rst_cyc", b_cyc, 0);
        chk("rst_bdone", b_bd, 0);
        chk("rst_to", b_to, 0);
        reset = 1'b0;
        @(negedge clk);

        run_single(-1, 7);
        run_single(1, 2);
        run_single(1, 6);
        run_single(-1, 40);
        chk("a_to_clear", a_to, 0);
        chk("s_to_clear", s_to, 0);

        run_batch();
        run_reset_mid();
`ifdef LAUNCHER_TIMEOUT_EN
        run_timeout();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_launcher.md
Name: cpu_launcher

Overview:
Host-side initiator for the processor's req/done handshake. It runs NUM_PROGS programs back to back. For each program it selects the program index, pulses req and counts cycles until done. It then publishes a per-program cycle-count result. It sits in the bench/host wrapper that instantiates the processor top level and drives its clk/reset/req, and it consumes done.

Parameters:
NUM_PROGS, 3, number of programs run per start command (1..8)
CNT_W, 16, width of the per-program cycle counter
TIMEOUT_CYC, 4096, run-length limit in cycles (used only with LAUNCHER_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle command; begins a batch when idle
cpu_req  out  1  request pulse to the processor
cpu_done  in  1  processor completion level
prog_sel  out  3  index of the program currently launched
busy  out  1  high from batch acceptance until batch end
res_valid  out  1  one-cycle strobe: result fields valid
res_idx  out  3  program index of the result
res_cycles  out  CNT_W  cycles from req to done, saturating
batch_done  out  1  one-cycle strobe when the final result is issued
timeout_err  out  1  sticky; set on run timeout (LAUNCHER_TIMEOUT_EN only)

Behaviour:
- Reset is synchronous and active-high. It sets all outputs to 0, the FSM to IDLE, and the counter to 0. Reset has priority over everything. Asserting reset mid-run abandons the batch and produces no res_valid.
- FSM states: IDLE, LAUNCH, RUN, RECORD, DRAIN.
- IDLE: when start=1, go to LAUNCH with prog_sel=0 and busy=1. start is ignored in every other state.
- LAUNCH: cpu_req=1 for exactly this one cycle. Clear the counter to 0. Next state is RUN.
- RUN: the counter increments by 1 each cycle and saturates at all-ones; it does not wrap. cpu_done is ignored in the first RUN cycle, because done may still be high from the previous program. From the second RUN cycle on, cpu_done=1 leads to RECORD.
- RECORD: one cycle. res_valid=1, res_idx=prog_sel, res_cycles=counter. If prog_sel==NUM_PROGS-1, batch_done=1 in the same cycle and the next state is IDLE with busy=0 on the following cycle. Otherwise the next state is DRAIN.
- DRAIN: wait for cpu_done=0. Then increment prog_sel and go to LAUNCH, so there is at least one low cycle of done between programs. If done is already low on entry, leave DRAIN after 1 cycle.
- Latency: with done high on the Nth cycle after req, res_cycles=N and res_valid appears 1 cycle after done is sampled.
- Simultaneous start and reset: reset wins.
- cpu_req and res_valid are never high in the same cycle.

Optional Feature:
LAUNCHER_TIMEOUT_EN
- Defined: in RUN, if the counter reaches TIMEOUT_CYC-1 without done, go to RECORD with res_cycles=all-ones and set timeout_err. timeout_err is sticky until reset. The batch continues with the next program.
- Undefined: RUN waits indefinitely for done, timeout_err is tied to 0, and TIMEOUT_CYC is unused.

Decomposition:
- launcher_pkg holds:
  - the state enum typedef (IDLE, LAUNCH, RUN, RECORD, DRAIN)
  - localparam PROG_W=3
  - a typedef for the result record {idx, cycles}
- One sub-module, sat_counter, parameterised by width, with clear and enable inputs and a saturating output. It is used for the run counter.

Test Plan:
- Single program: NUM_PROGS=1, start at cycle 5, done rises 7 cycles after req. Expect res_valid with res_idx=0 and res_cycles=7, batch_done in the same cycle, and busy=0 on the next cycle.
- Stale done: cpu_done held high through LAUNCH and the first RUN cycle. Expect it ignored; no result until done is low, then high again from the 2nd RUN cycle, or held high, in which case the result gives res_cycles=2.
- Batch of 3: runs take 4, 10 and 1 cycles, with done kept high 3 cycles each. Expect results idx 0,1,2 with cycles 4,10,2 (the 1-cycle done is ignored, so the minimum is 2). Expect exactly one req per program and DRAIN waiting for done low between programs.
- Saturation: CNT_W=4 with done after 40 cycles. Expect res_cycles=15.
- Reset mid-RUN: assert reset during program 1. Expect all outputs 0, no res_valid, IDLE. A fresh start restarts at prog_sel=0.
- With LAUNCHER_TIMEOUT_EN, TIMEOUT_CYC=16 and done never asserted: expect res_cycles=all-ones after 16 RUN cycles, timeout_err=1 and staying 1, and the next program launched.
